// File: rtl/farbborg_pkg.sv
// Shared geometry constants, scan state encoding and a plane decode helper
// for the farbborg LED cube scanner.
package farbborg_pkg;

  localparam int N_PLANES        = 8;
  localparam int WORDS_PER_PLANE = 32;
  localparam int LEDS_PER_PLANE  = 64;
  // Fetch counter value of the last cycle of FETCH (compare of the final word)
  localparam int FETCH_LAST      = WORDS_PER_PLANE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } scan_state_t;

  function automatic logic [N_PLANES-1:0] plane_onehot(input logic [2:0] plane);
    plane_onehot        = '0;
    plane_onehot[plane] = 1'b1;
  endfunction

endpackage

// File: rtl/farbborg_pwm_cmp.sv
// PWM threshold compare for one frame RAM word: each byte is an LED brightness,
// the LED is lit while its brightness exceeds the current PWM level.
module farbborg_pwm_cmp (
  input  logic [15:0] word,
  input  logic [7:0]  level,
  output logic [1:0]  on_mask
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_led
    assign on_mask[gi] = (word[gi*8 +: 8] > level);
  end

endmodule

// File: rtl/farbborg_scan.sv
// Bit-angle-free PWM scanner: fetches one plane from frame RAM per step,
// thresholds it against the current level and latches it onto the column drivers.
module farbborg_scan
  import farbborg_pkg::*;
#(
  parameter int HOLD_CYCLES = 32,
  parameter int PWM_MAX     = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic [7:0]                ram_addr,
  input  logic [15:0]               ram_data,
  output logic [LEDS_PER_PLANE-1:0] col_out,
  output logic [N_PLANES-1:0]       plane_sel,
  output logic                      latch,
  output logic                      frame_start,
  output logic                      busy
);

  localparam int HOLD_LEN = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int CNT_MAX  = (HOLD_LEN > FETCH_LAST) ? HOLD_LEN : FETCH_LAST;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(HOLD_LEN - 1);
  localparam logic [CNT_W-1:0] FETCH_END = CNT_W'(FETCH_LAST);
  localparam logic [7:0]       LEVEL_TOP = 8'(PWM_MAX - 1);

  scan_state_t               state_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [7:0]                level_reg;
  logic [2:0]                plane_reg;
  // The final word never lands here; it goes straight into col_out at LATCH entry
  logic [LEDS_PER_PLANE-3:0] shadow_reg;
  logic [1:0]                on_mask;
  logic [4:0]                word_idx;

  farbborg_pwm_cmp u_cmp (
    .word    (ram_data),
    .level   (level_reg),
    .on_mask (on_mask)
  );

  // RAM data in fetch cycle c belongs to the word addressed in cycle c-1
  assign word_idx = 5'(cnt_reg - 1'b1);
  assign ram_addr = (state_reg == FETCH && cnt_reg < FETCH_END) ? {plane_reg, cnt_reg[4:0]} : 8'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      level_reg   <= '0;
      plane_reg   <= '0;
      shadow_reg  <= '0;
      col_out     <= '0;
      plane_sel   <= '0;
      latch       <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      latch       <= 1'b0;
      frame_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg <= FETCH;
            cnt_reg   <= '0;
            level_reg <= '0;
            plane_reg <= '0;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (cnt_reg != '0 && cnt_reg != FETCH_END) begin
            shadow_reg[{word_idx, 1'b0} +: 2] <= on_mask;
          end
          if (cnt_reg == FETCH_END) begin
            state_reg   <= LATCH;
            cnt_reg     <= '0;
            col_out     <= {on_mask, shadow_reg};
            plane_sel   <= plane_onehot(plane_reg);
            latch       <= 1'b1;
            frame_start <= (plane_reg == 3'd0) && (level_reg == 8'd0);
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        LATCH: begin
          state_reg <= HOLD;
          cnt_reg   <= '0;
          if (level_reg == LEVEL_TOP) begin
            level_reg <= '0;
            plane_reg <= plane_reg + 3'd1;
          end else begin
            level_reg <= level_reg + 8'd1;
          end
        end
        HOLD: begin
          if (cnt_reg == HOLD_END) begin
            cnt_reg <= '0;
            if (enable) begin
              state_reg <= FETCH;
            end else begin
              state_reg <= IDLE;
              col_out   <= '0;
              plane_sel <= '0;
              level_reg <= '0;
              plane_reg <= '0;
              busy      <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_farbborg_scan.sv
// Scoreboard bench for farbborg_scan: expected latch contents are queued from a
// reference model and popped whenever a DUT latch strobe is observed.
module tb_farbborg_scan;

  localparam int HOLD  = 4;
  localparam int PWM_A = 4;
  localparam int PWM_B = 255;

  typedef struct packed {
    logic [63:0] col;
    logic [7:0]  psel;
    logic        fs;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_na, ena, rst_nb, enb;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic [63:0] col_a, col_b;
  logic [7:0]  psel_a, psel_b;
  logic        latch_a, latch_b, fs_a, fs_b, busy_a, busy_b;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int na = 0;
  int nb = 0;
  int ma_level, ma_plane, mb_level, mb_plane;

  farbborg_scan #(.HOLD_CYCLES(HOLD), .PWM_MAX(PWM_A)) dut_a (
    .clk(clk), .rst_n(rst_na), .enable(ena), .ram_addr(addr_a), .ram_data(data_a),
    .col_out(col_a), .plane_sel(psel_a), .latch(latch_a), .frame_start(fs_a), .busy(busy_a)
  );

  farbborg_scan #(.HOLD_CYCLES(HOLD), .PWM_MAX(PWM_B)) dut_b (
    .clk(clk), .rst_n(rst_nb), .enable(enb), .ram_addr(addr_b), .ram_data(data_b),
    .col_out(col_b), .plane_sel(psel_b), .latch(latch_b), .frame_start(fs_b), .busy(busy_b)
  );

  // Synchronous-read frame RAMs
  always @(posedge clk) begin
    data_a <= mem_a[addr_a];
    data_b <= mem_b[addr_b];
  end

  function automatic exp_t model_step(input logic [15:0] m [256], input int p, input int l);
    exp_t e;
    logic [15:0] w;
    e.col = '0;
    for (int i = 0; i < 32; i++) begin
      w = m[p*32 + i];
      e.col[2*i]   = (int'(w[7:0]) > l);
      e.col[2*i+1] = (int'(w[15:8]) > l);
    end
    e.psel = 8'h01 << p;
    e.fs   = (p == 0) && (l == 0);
    return e;
  endfunction

  task automatic push_a(input int count);
    for (int i = 0; i < count; i++) begin
      qa.push_back(model_step(mem_a, ma_plane, ma_level));
      ma_level++;
      if (ma_level == PWM_A) begin
        ma_level = 0;
        ma_plane = (ma_plane + 1) % 8;
      end
    end
  endtask

  task automatic push_b(input int count);
    for (int i = 0; i < count; i++) begin
      qb.push_back(model_step(mem_b, mb_plane, mb_level));
      mb_level++;
      if (mb_level == PWM_B) begin
        mb_level = 0;
        mb_plane = (mb_plane + 1) % 8;
      end
    end
  endtask

  // One clock step; any latch strobe is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (latch_a) begin
      na++;
      $display("latch a cyc=%0d psel=%02h fs=%0b col=%016h", cyc, psel_a, fs_a, col_a);
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL latch_a_unexpected cyc=%0d got latch=1 want no latch", cyc);
      end else begin
        e = qa.pop_front();
        checks++;
        if (col_a !== e.col) begin
          errors++;
          $display("FAIL col_a cyc=%0d got %016h want %016h", cyc, col_a, e.col);
        end
        checks++;
        if (psel_a !== e.psel) begin
          errors++;
          $display("FAIL plane_sel_a cyc=%0d got %02h want %02h", cyc, psel_a, e.psel);
        end
        checks++;
        if (fs_a !== e.fs) begin
          errors++;
          $display("FAIL frame_start_a cyc=%0d got %0b want %0b", cyc, fs_a, e.fs);
        end
      end
    end
    if (latch_b) begin
      nb++;
      $display("latch b cyc=%0d psel=%02h fs=%0b col=%016h", cyc, psel_b, fs_b, col_b);
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL latch_b_unexpected cyc=%0d got latch=1 want no latch", cyc);
      end else begin
        e = qb.pop_front();
        checks++;
        if (col_b !== e.col) begin
          errors++;
          $display("FAIL col_b cyc=%0d got %016h want %016h", cyc, col_b, e.col);
        end
        checks++;
        if (psel_b !== e.psel || fs_b !== e.fs) begin
          errors++;
          $display("FAIL psel_fs_b cyc=%0d got %02h/%0b want %02h/%0b", cyc, psel_b, fs_b, e.psel, e.fs);
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst_na = 1'b0;
    rst_nb = 1'b0;
    ena = 1'b0;
    enb = 1'b0;
    repeat (2) tick();
    rst_na = 1'b1;
    rst_nb = 1'b1;
    ma_level = 0; ma_plane = 0;
    mb_level = 0; mb_plane = 0;
  endtask

  task automatic wait_idle_a(input string name);
    int k;
    k = 0;
    while (busy_a && k < 60) begin
      tick();
      k++;
    end
    checks++;
    if (busy_a !== 1'b0 || col_a !== 64'd0 || psel_a !== 8'd0) begin
      errors++;
      $display("FAIL %s_idle busy=%0b col=%016h psel=%02h want 0/0/0", name, busy_a, col_a, psel_a);
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d outstanding latches want 0", name, qa.size());
    end
  endtask

  task automatic test_reset();
    rst_na = 1'b0;
    rst_nb = 1'b0;
    ena = 1'b1;
    enb = 1'b1;
    repeat (3) tick();
    checks++;
    if (col_a !== 64'd0) begin errors++; $display("FAIL reset_col got %016h want 0", col_a); end
    checks++;
    if (psel_a !== 8'd0) begin errors++; $display("FAIL reset_plane_sel got %02h want 00", psel_a); end
    checks++;
    if (latch_a !== 1'b0 || fs_a !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got latch=%0b fs=%0b want 0/0", latch_a, fs_a);
    end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_a); end
    checks++;
    if (addr_a !== 8'd0) begin errors++; $display("FAIL reset_addr got %02h want 00", addr_a); end
    checks++;
    if (busy_b !== 1'b0 || col_b !== 64'd0) begin
      errors++; $display("FAIL reset_b got busy=%0b col=%016h want 0/0", busy_b, col_b);
    end
    apply_reset();
  endtask

  task automatic test_first_latch();
    int start, n;
    for (int i = 0; i < 256; i++) mem_a[i] = 16'hFFFF;
    apply_reset();
    push_a(2);
    start = na;
    ena = 1'b1;
    n = 0;
    while (na == start && n < 100) begin tick(); n++; end
    checks++;
    if (n != 34) begin errors++; $display("FAIL first_latch_delay got %0d want 34", n); end
    n = 0;
    while (na == start + 1 && n < 100) begin tick(); n++; end
    checks++;
    if (n != 38) begin errors++; $display("FAIL latch_period got %0d want 38", n); end
    ena = 1'b0;
    wait_idle_a("first_latch");
  endtask

  task automatic test_plane_sequence();
    int start, t, k;
    for (int i = 0; i < 256; i++) mem_a[i] = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
    apply_reset();
    push_a(33);
    start = na;
    ena = 1'b1;
    t = -1;
    k = 0;
    while (na - start < 33 && k < 1400) begin
      tick();
      k++;
      if (latch_a) begin
        if (na - start > 1) begin
          checks++;
          if (t + 1 != 38) begin errors++; $display("FAIL seq_spacing got %0d want 38", t + 1); end
        end
        t = 0;
      end else if (t >= 0) begin
        t++;
        if (na - start == 20 && t >= 5 && t <= 36) begin
          checks++;
          if (addr_a !== 8'(8'hA0 + t - 5)) begin
            errors++; $display("FAIL plane5_addr got %02h want %02h", addr_a, 8'(8'hA0 + t - 5));
          end
        end else if (na - start == 20 && t >= 1 && t <= 4) begin
          checks++;
          if (addr_a !== 8'd0) begin errors++; $display("FAIL hold_addr got %02h want 00", addr_a); end
        end
      end
    end
    checks++;
    if (na - start != 33) begin errors++; $display("FAIL seq_count got %0d want 33", na - start); end
    ena = 1'b0;
    wait_idle_a("plane_sequence");
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 256; i++) mem_a[i] = 16'($urandom);
    apply_reset();
    push_a(1);
    ena = 1'b1;
    repeat (11) tick();
    ena = 1'b0;
    for (int n = 12; n <= 39; n++) begin
      tick();
      if (n == 34) begin
        checks++;
        if (latch_a !== 1'b1) begin errors++; $display("FAIL drop_latch got %0b want 1", latch_a); end
      end
      if (n == 38) begin
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL drop_hold_busy got %0b want 1", busy_a); end
      end
    end
    checks++;
    if (busy_a !== 1'b0 || col_a !== 64'd0 || psel_a !== 8'd0) begin
      errors++;
      $display("FAIL drop_idle busy=%0b col=%016h psel=%02h want 0/0/0", busy_a, col_a, psel_a);
    end
    repeat (50) tick();
    wait_idle_a("enable_drop");
  endtask

  task automatic test_reset_mid_fetch();
    int start, n;
    for (int i = 0; i < 256; i++) mem_a[i] = 16'($urandom);
    apply_reset();
    ena = 1'b1;
    repeat (21) tick();
    rst_na = 1'b0;
    tick();
    checks++;
    if (col_a !== 64'd0 || psel_a !== 8'd0 || latch_a !== 1'b0 || fs_a !== 1'b0 ||
        busy_a !== 1'b0 || addr_a !== 8'd0) begin
      errors++;
      $display("FAIL midreset_outputs col=%016h psel=%02h latch=%0b fs=%0b busy=%0b addr=%02h want all 0",
               col_a, psel_a, latch_a, fs_a, busy_a, addr_a);
    end
    rst_na = 1'b1;
    ma_level = 0; ma_plane = 0;
    push_a(1);
    start = na;
    n = 0;
    while (na == start && n < 100) begin tick(); n++; end
    checks++;
    if (n != 34) begin errors++; $display("FAIL restart_latch_delay got %0d want 34", n); end
    ena = 1'b0;
    wait_idle_a("reset_mid_fetch");
  endtask

  task automatic test_threshold_b();
    int start, k;
    for (int i = 0; i < 256; i++) mem_b[i] = 16'h0000;
    mem_b[0] = 16'h0280;
    apply_reset();
    push_b(PWM_B);
    start = nb;
    enb = 1'b1;
    k = 0;
    while (nb - start < PWM_B && k < PWM_B * 38 + 200) begin tick(); k++; end
    enb = 1'b0;
    checks++;
    if (nb - start != PWM_B) begin errors++; $display("FAIL threshold_count got %0d want %0d", nb - start, PWM_B); end
    k = 0;
    while (busy_b && k < 60) begin tick(); k++; end
    checks++;
    if (busy_b !== 1'b0 || col_b !== 64'd0 || qb.size() != 0) begin
      errors++;
      $display("FAIL threshold_idle busy=%0b col=%016h pending=%0d want 0/0/0", busy_b, col_b, qb.size());
    end
  endtask

  initial begin
    rst_na = 1'b0;
    rst_nb = 1'b0;
    ena = 1'b0;
    enb = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    test_reset();
    test_first_latch();
    test_plane_sequence();
    test_enable_drop();
    test_reset_mid_fetch();
    test_threshold_b();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/farbborg_scan.md
FARBBORG_SCAN -- requirements
Module: farbborg_scan

Interface
REQ-001 Parameter: HOLD_CYCLES, default 32, display cycles inserted after each latch before the next fetch starts.
REQ-002 Parameter: PWM_MAX, default 255, number of PWM levels per plane (levels 0..PWM_MAX-1).
REQ-003 clk  input  1  single system clock; clocks the frame RAM read port too.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  scan run request.
REQ-006 ram_addr  output  8  frame RAM read address, {plane[2:0], word[4:0]}.
REQ-007 ram_data  input  16  frame RAM read data, valid one clk after ram_addr; [7:0] = LED 2w, [15:8] = LED 2w+1.
REQ-008 col_out  output  64  column drive for the active plane, 1 = LED on.
REQ-009 plane_sel  output  8  one-hot plane drive, all-zero = blanked.
REQ-010 latch  output  1  one-cycle strobe, high in the cycle col_out/plane_sel update.
REQ-011 frame_start  output  1  one-cycle strobe coincident with latch when plane 0, level 0 is shown.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 States: IDLE, FETCH, LATCH, HOLD; one state register, no other state.
REQ-014 IDLE -> FETCH when enable = 1; level and plane counters start at 0.
REQ-015 FETCH lasts exactly 33 cycles: ram_addr = {plane, w} for w = 0..31 in cycles 0..31; data compared in cycles 1..32.
REQ-016 Compare: shadow bit 2w = (ram_data[7:0] > level), bit 2w+1 = (ram_data[15:8] > level); brightness 0 is always off, brightness >= PWM_MAX always on.
REQ-017 FETCH -> LATCH after cycle 32; LATCH is one cycle: col_out <= shadow, plane_sel <= onehot(plane), latch = 1.
REQ-018 In LATCH: level increments; on level = PWM_MAX-1, level wraps to 0 and plane increments, wrapping 7 -> 0.
REQ-019 frame_start = 1 in the LATCH cycle whose displayed plane = 0 and level = 0.
REQ-020 LATCH -> HOLD; HOLD lasts HOLD_CYCLES cycles (HOLD_CYCLES = 0 gives one cycle minimum), then -> FETCH if enable = 1, else -> IDLE.
REQ-021 col_out and plane_sel hold their value through HOLD and the following FETCH; one step period = 34 + HOLD_CYCLES cycles.
REQ-022 Entering IDLE from HOLD: col_out = 0, plane_sel = 0, level = 0, plane = 0 next cycle.
REQ-023 enable deasserted during FETCH or LATCH does not abort the step; it is evaluated only in IDLE and at HOLD end.
REQ-024 ram_addr = 0 in IDLE, LATCH and HOLD.

Reset
REQ-025 rst_n = 0 at a rising clk forces state IDLE, level 0, plane 0, shadow 0, col_out 0, plane_sel 0, latch 0, frame_start 0, busy 0, ram_addr 0.
REQ-026 Reset mid-FETCH discards the partial shadow; no latch pulse is emitted for that step.

Structure
REQ-027 Shared package farbborg_pkg holds N_PLANES = 8, WORDS_PER_PLANE = 32, LEDS_PER_PLANE = 64, and the state encoding.
REQ-028 One sub-module, farbborg_pwm_cmp: combinational 16-bit word vs 8-bit level -> 2-bit on-mask; instantiated once.

Verification
REQ-029 RAM model all 0xFFFF, enable = 1, HOLD_CYCLES = 4 -> first latch 34 cycles after FETCH start, col_out = all ones, plane_sel = 8'h01, frame_start = 1.
REQ-030 Plane 0 word 0 = 16'h0280, others 0 -> col_out[0] = 1 for levels 0..127, 0 from level 128; col_out[1] = 1 for levels 0..1 only.
REQ-031 Run PWM_MAX = 4 -> plane_sel sequence 01 x4, 02 x4, ..., 80 x4, then 01 with frame_start = 1; latch spacing = 38 cycles.
REQ-032 Drop enable in FETCH cycle 10 -> step completes, latch pulses, HOLD completes, IDLE: col_out = 0, plane_sel = 0, busy = 0.
REQ-033 Assert rst_n = 0 in FETCH cycle 20 for one cycle -> all outputs 0 next cycle, no latch; restart gives frame_start on first latch.
REQ-034 Check ram_addr during FETCH of plane 5 -> 8'hA0..8'hBF in consecutive cycles.
